// File: rtl/fmalza_pipe.sv
// fmalza_pipe: two-stage leading-zero anticipation check pipeline with valid/ready handshake and saturating statistics
module fmalza_pipe #(
  parameter int WIDTH = 8,
  parameter int CNTW = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic [WIDTH-1:0]              A,
  input  logic [WIDTH-1:0]              B,
  input  logic                          Cin,
  input  logic                          Sub,
  input  logic                          Flush,
  input  logic                          StatClr,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [$clog2(WIDTH+2)-1:0]    SCnt,
  output logic [$clog2(WIDTH+2)-1:0]    ECnt,
  output logic                          Corr,
  output logic                          Miss,
  output logic [CNTW-1:0]               CorrTot,
  output logic [CNTW-1:0]               MissTot,
  output logic [CNTW-1:0]               BeatTot
);
  localparam int CW = $clog2(WIDTH+2);
  logic [WIDTH-1:0] p, g, k, pp1, gm1, km1;
  logic [WIDTH:0] f, z, sum, s1_f, s1_z;
  logic s1_v, s1_adv, s2_adv, acc, hs, corr_n, miss_n;
  logic [CW-1:0] lz_f, lz_z;
  logic [CW:0] scnt_p1;

  function automatic logic [CW-1:0] lzc(input logic [WIDTH:0] v);
    lzc = CW'(WIDTH + 1);
    for (int i = 0; i <= WIDTH; i++) if (v[i]) lzc = CW'(WIDTH - i);
  endfunction

  // anticipation vector and exact sum of the incoming beat
  always_comb begin
    p = A ^ B;
    g = A & B;
    k = ~A & ~B;
    pp1 = WIDTH'({Sub, p} >> 1);
    gm1 = {g[WIDTH-2:0], Cin};
    km1 = {k[WIDTH-2:0], ~Cin};
    f = {~Sub & p[WIDTH-1], (pp1 & (g & ~km1 | k & ~gm1)) | (~pp1 & (k & ~km1 | g & ~gm1))};
    sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    z = {~Sub & sum[WIDTH], sum[WIDTH-1:0]};
  end

  assign s2_adv  = ~OutValid | OutReady;
  assign s1_adv  = s1_v & s2_adv;
  assign InReady = reset_n & ~Flush & (~s1_v | s1_adv);
  assign acc     = InValid & InReady;
  assign hs      = OutValid & OutReady & ~Flush;
  assign lz_f    = lzc(s1_f);
  assign lz_z    = lzc(s1_z);
  assign scnt_p1 = {1'b0, lz_f} + (CW+1)'(1);
  assign corr_n  = {1'b0, lz_z} == scnt_p1;
  assign miss_n  = ~corr_n & (lz_z != lz_f);

  // stage 1: capture anticipation vector and exact result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v <= 1'b0;
      s1_f <= '0;
      s1_z <= '0;
    end else begin
      s1_v <= ~Flush & (acc | (s1_v & ~s1_adv));
      if (acc) begin
        s1_f <= f;
        s1_z <= z;
      end
    end
  end

  // stage 2: shift counts and their comparison, held while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      OutValid <= 1'b0;
      SCnt <= '0;
      ECnt <= '0;
      Corr <= 1'b0;
      Miss <= 1'b0;
    end else begin
      OutValid <= ~Flush & (s1_adv | (OutValid & ~OutReady));
      if (s1_adv) begin
        SCnt <= lz_f;
        ECnt <= lz_z;
        Corr <= corr_n;
        Miss <= miss_n;
      end
    end
  end

  // saturating statistics; clear and flush both suppress counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      BeatTot <= '0;
      CorrTot <= '0;
      MissTot <= '0;
    end else if (StatClr) begin
      BeatTot <= '0;
      CorrTot <= '0;
      MissTot <= '0;
    end else if (hs) begin
      BeatTot <= BeatTot + CNTW'(~&BeatTot);
      CorrTot <= CorrTot + CNTW'(Corr & ~&CorrTot);
      MissTot <= MissTot + CNTW'(Miss & ~&MissTot);
    end
  end
endmodule

// File: tb/tb_fmalza_pipe.sv
// tb_fmalza_pipe: directed self-checking bench for fmalza_pipe
module tb_fmalza_pipe;
  logic clk = 1'b0;
  logic reset_n, InValid, InReady, Cin, Sub, Flush, StatClr, OutValid, OutReady, Corr, Miss;
  logic [7:0] A, B;
  logic [3:0] SCnt, ECnt;
  logic [15:0] CorrTot, MissTot, BeatTot;
  logic s_InReady, s_OutValid, s_Corr, s_Miss;
  logic [3:0] s_SCnt, s_ECnt;
  logic [1:0] s_CorrTot, s_MissTot, s_BeatTot;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] a, b;
    logic cin, sub;
    logic [3:0] sc, ec;
    logic co, mi;
  } vec_t;

  always #5 clk = ~clk;

  fmalza_pipe #(.WIDTH(8), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady), .A(A), .B(B),
    .Cin(Cin), .Sub(Sub), .Flush(Flush), .StatClr(StatClr), .OutValid(OutValid),
    .OutReady(OutReady), .SCnt(SCnt), .ECnt(ECnt), .Corr(Corr), .Miss(Miss),
    .CorrTot(CorrTot), .MissTot(MissTot), .BeatTot(BeatTot)
  );

  fmalza_pipe #(.WIDTH(8), .CNTW(2)) sat (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(s_InReady), .A(A), .B(B),
    .Cin(Cin), .Sub(Sub), .Flush(Flush), .StatClr(StatClr), .OutValid(s_OutValid),
    .OutReady(OutReady), .SCnt(s_SCnt), .ECnt(s_ECnt), .Corr(s_Corr), .Miss(s_Miss),
    .CorrTot(s_CorrTot), .MissTot(s_MissTot), .BeatTot(s_BeatTot)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    InValid = 0; A = 0; B = 0; Cin = 0; Sub = 0; Flush = 0; StatClr = 0;
  endtask

  task automatic do_reset();
    idle();
    OutReady = 1;
    reset_n = 0;
    step();
    reset_n = 1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1;
    idle();
    OutReady = 1;
    #3 reset_n = 0;
    #1;
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL rst_outvalid got=%0d exp=0", OutValid); end
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL rst_inready got=%0d exp=0", InReady); end
    checks++; if ({SCnt, ECnt} !== 8'h00) begin failures++; $display("FAIL rst_cnts got=%0d/%0d exp=0/0", SCnt, ECnt); end
    checks++; if ({Corr, Miss} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%0d/%0d exp=0/0", Corr, Miss); end
    checks++; if ({CorrTot, MissTot, BeatTot} !== 48'h0) begin failures++; $display("FAIL rst_tots got=%0d/%0d/%0d exp=0", CorrTot, MissTot, BeatTot); end
    step();
    reset_n = 1;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL rst_release_inready got=%0d exp=1", InReady); end
    step();
  endtask

  task automatic test_vectors();
    vec_t tv[5];
    tv[0] = '{8'h01, 8'h00, 1'b0, 1'b0, 4'd7, 4'd8, 1'b1, 1'b0};
    tv[1] = '{8'h80, 8'h80, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b1};
    tv[2] = '{8'hC0, 8'h40, 1'b1, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0};
    tv[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0};
    tv[4] = '{8'hFF, 8'h01, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      A = tv[i].a; B = tv[i].b; Cin = tv[i].cin; Sub = tv[i].sub; InValid = 1;
      step();
      idle();
      checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL vec%0d_early_valid got=%0d exp=0", i, OutValid); end
      step();
      checks++; if (OutValid !== 1'b1) begin failures++; $display("FAIL vec%0d_valid got=%0d exp=1", i, OutValid); end
      checks++; if (SCnt !== tv[i].sc) begin failures++; $display("FAIL vec%0d_scnt got=%0d exp=%0d", i, SCnt, tv[i].sc); end
      checks++; if (ECnt !== tv[i].ec) begin failures++; $display("FAIL vec%0d_ecnt got=%0d exp=%0d", i, ECnt, tv[i].ec); end
      checks++; if ({Corr, Miss} !== {tv[i].co, tv[i].mi}) begin failures++; $display("FAIL vec%0d_flags got=%0d/%0d exp=%0d/%0d", i, Corr, Miss, tv[i].co, tv[i].mi); end
      step();
    end
    checks++; if (BeatTot !== 16'd5) begin failures++; $display("FAIL vec_beattot got=%0d exp=5", BeatTot); end
    checks++; if (CorrTot !== 16'd1) begin failures++; $display("FAIL vec_corrtot got=%0d exp=1", CorrTot); end
    checks++; if (MissTot !== 16'd1) begin failures++; $display("FAIL vec_misstot got=%0d exp=1", MissTot); end
  endtask

  task automatic test_back_to_back(input int stall, input int exp_cyc);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    do_reset();
    for (cyc = 0; cyc < 20 && got < 4; cyc++) begin
      OutReady = cyc >= stall;
      InValid = sent < 4;
      A = 8'(1 << sent);
      #1;
      if (stall > 0 && cyc == 2) begin
        checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL b2b_inready_full got=%0d exp=0", InReady); end
        checks++; if ({OutValid, ECnt} !== 5'h18) begin failures++; $display("FAIL b2b_hold got=%0d/%0d exp=1/8", OutValid, ECnt); end
      end
      if (OutValid && OutReady) begin
        checks++; if (ECnt !== 4'(8 - got)) begin failures++; $display("FAIL b2b_order%0d got=%0d exp=%0d", got, ECnt, 8 - got); end
        got++;
      end
      if (InValid && InReady) sent++;
      step();
    end
    idle();
    checks++; if (got !== 4) begin failures++; $display("FAIL b2b_count stall=%0d got=%0d exp=4", stall, got); end
    checks++; if (cyc !== exp_cyc) begin failures++; $display("FAIL b2b_cycles stall=%0d got=%0d exp=%0d", stall, cyc, exp_cyc); end
    checks++; if (BeatTot !== 16'd4) begin failures++; $display("FAIL b2b_beattot got=%0d exp=4", BeatTot); end
    checks++; if (CorrTot !== 16'd4) begin failures++; $display("FAIL b2b_corrtot got=%0d exp=4", CorrTot); end
  endtask

  task automatic test_flush();
    do_reset();
    A = 8'h01; InValid = 1;
    step();
    idle();
    step();
    step();
    checks++; if (BeatTot !== 16'd1) begin failures++; $display("FAIL flush_pre_beattot got=%0d exp=1", BeatTot); end
    OutReady = 0;
    A = 8'h01; InValid = 1;
    step();
    A = 8'h02;
    step();
    checks++; if (OutValid !== 1'b1) begin failures++; $display("FAIL flush_inflight got=%0d exp=1", OutValid); end
    A = 8'h04; Flush = 1; OutReady = 1;
    #1;
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL flush_inready got=%0d exp=0", InReady); end
    step();
    idle();
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL flush_outvalid got=%0d exp=0", OutValid); end
    checks++; if ({BeatTot, CorrTot} !== {16'd1, 16'd1}) begin failures++; $display("FAIL flush_tots got=%0d/%0d exp=1/1", BeatTot, CorrTot); end
    step();
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%0d exp=0", OutValid); end
  endtask

  task automatic test_sat();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      A = 8'h01; InValid = 1;
      step();
    end
    idle();
    step(); step(); step();
    checks++; if (s_CorrTot !== 2'd3) begin failures++; $display("FAIL sat_corrtot got=%0d exp=3", s_CorrTot); end
    checks++; if (s_BeatTot !== 2'd3) begin failures++; $display("FAIL sat_beattot got=%0d exp=3", s_BeatTot); end
    checks++; if (CorrTot !== 16'd5) begin failures++; $display("FAIL wide_corrtot got=%0d exp=5", CorrTot); end
    A = 8'h01; InValid = 1;
    step();
    idle();
    step();
    StatClr = 1;
    step();
    StatClr = 0;
    checks++; if ({s_CorrTot, s_BeatTot} !== 4'h0) begin failures++; $display("FAIL statclr_sat got=%0d/%0d exp=0/0", s_CorrTot, s_BeatTot); end
    checks++; if ({CorrTot, BeatTot} !== 32'h0) begin failures++; $display("FAIL statclr_wide got=%0d/%0d exp=0/0", CorrTot, BeatTot); end
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL statclr_consumed got=%0d exp=0", OutValid); end
    step();
    checks++; if (BeatTot !== 16'd0) begin failures++; $display("FAIL statclr_after got=%0d exp=0", BeatTot); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    A = 8'h01; InValid = 1;
    step();
    A = 8'h02;
    step();
    A = 8'h04;
    #2 reset_n = 0;
    #1;
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL midrst_outvalid got=%0d exp=0", OutValid); end
    checks++; if ({SCnt, ECnt} !== 8'h00) begin failures++; $display("FAIL midrst_cnts got=%0d/%0d exp=0/0", SCnt, ECnt); end
    checks++; if ({Corr, InReady} !== 2'b00) begin failures++; $display("FAIL midrst_corr_inready got=%0d/%0d exp=0/0", Corr, InReady); end
    idle();
    step();
    reset_n = 1;
    step();
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL midrst_lost got=%0d exp=0", OutValid); end
    A = 8'h80; B = 8'h80; InValid = 1;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL midrst_resume got=%0d exp=1", InReady); end
    step();
    idle();
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL midrst_early got=%0d exp=0", OutValid); end
    step();
    checks++; if ({OutValid, SCnt, ECnt, Miss} !== {1'b1, 4'd1, 4'd0, 1'b1}) begin failures++; $display("FAIL midrst_beat got=v%0d s%0d e%0d m%0d exp=v1 s1 e0 m1", OutValid, SCnt, ECnt, Miss); end
    step();
    checks++; if (MissTot !== 16'd1) begin failures++; $display("FAIL midrst_misstot got=%0d exp=1", MissTot); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back(3, 7);
    test_back_to_back(0, 6);
    test_flush();
    test_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fmalza_pipe.md
FMALZA_PIPE -- requirements
Module: fmalza_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (WIDTH >= 4).
REQ-002 SHALL have parameter CNTW, default 16, meaning width of each statistics counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port InValid  input  1  operand beat valid.
REQ-006 SHALL have port InReady  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port A  input  WIDTH  aligned addend, pre-inverted by sender when Sub=1.
REQ-008 SHALL have port B  input  WIDTH  second operand (zero-extended product).
REQ-009 SHALL have port Cin  input  1  carry in.
REQ-010 SHALL have port Sub  input  1  effective subtraction flag.
REQ-011 SHALL have port Flush  input  1  discard all in-flight beats.
REQ-012 SHALL have port StatClr  input  1  synchronous clear of statistics counters.
REQ-013 SHALL have port OutValid  output  1  result beat valid.
REQ-014 SHALL have port OutReady  input  1  consumer accepts the result beat.
REQ-015 SHALL have port SCnt  output  $clog2(WIDTH+2)  anticipated shift count.
REQ-016 SHALL have port ECnt  output  $clog2(WIDTH+2)  exact shift count.
REQ-017 SHALL have port Corr  output  1  ECnt == SCnt+1 (one-bit correction needed).
REQ-018 SHALL have port Miss  output  1  ECnt not in {SCnt, SCnt+1}.
REQ-019 SHALL have ports CorrTot, MissTot, BeatTot  output  CNTW each  saturating statistics counters.

Function
REQ-020 SHALL compute P=A^B, G=A&B, K=~A&~B; Pp1={Sub,P[W-1:1]}; Gm1={G[W-2:0],Cin}; Km1={K[W-2:0],~Cin}.
REQ-021 SHALL form F[WIDTH]=~Sub&P[W-1] and F[W-1:0]=(Pp1&(G&~Km1|K&~Gm1))|(~Pp1&(K&~Km1|G&~Gm1)).
REQ-022 SHALL set SCnt = leading-zero count of the WIDTH+1-bit F, = WIDTH+1 when F is all zero.
REQ-023 SHALL form Z = {~Sub & carry-out, (A+B+Cin) mod 2^WIDTH}; ECnt = leading-zero count of Z, = WIDTH+1 when Z is zero.
REQ-024 SHALL be a two-stage pipeline: stage 1 registers F and Z; stage 2 registers SCnt, ECnt, Corr, Miss.
REQ-025 SHALL give latency exactly 2 cycles from accepted beat (InValid&InReady) to OutValid with no back-pressure.
REQ-026 SHALL advance each stage when its successor is empty or being emptied the same cycle; InReady = ~S1Valid | S1Advance.
REQ-027 SHALL hold SCnt, ECnt, Corr, Miss stable while OutValid=1 and OutReady=0.
REQ-028 SHALL sustain one beat per cycle when OutReady=1 continuously.
REQ-029 SHALL on Flush=1 clear both stage valids at the next edge, force InReady=0 that cycle, and drop any input beat presented.
REQ-030 SHALL give Flush priority over handshakes; counters SHALL NOT count a beat discarded by Flush.
REQ-031 SHALL increment BeatTot on each output handshake (OutValid&OutReady), CorrTot when additionally Corr=1, MissTot when additionally Miss=1.
REQ-032 SHALL saturate counters at 2^CNTW-1, never wrapping.
REQ-033 SHALL on StatClr=1 zero all counters; a simultaneous handshake SHALL NOT be counted.

Reset
REQ-034 SHALL on reset_n=0 asynchronously clear stage valids, OutValid=0, SCnt=ECnt=0, Corr=Miss=0, all counters=0.
REQ-035 SHALL hold InReady=0 while reset_n=0; beats in flight at reset assertion are lost.
REQ-036 SHALL resume accepting on the first rising edge after reset_n deasserts.

Verification
REQ-037 SHALL cover WIDTH=8, A=0x01,B=0x00,Cin=0,Sub=0 -> after 2 cycles SCnt=7, ECnt=8, Corr=1, Miss=0.
REQ-038 SHALL cover WIDTH=8, A=0x80,B=0x80,Cin=0,Sub=0 -> SCnt=1, ECnt=0, Miss=1, MissTot=1.
REQ-039 SHALL cover 4 back-to-back beats with OutReady=0 for 3 cycles -> InReady drops after 2 held beats, no loss, order preserved, BeatTot=4 after drain.
REQ-040 SHALL cover Flush with 2 beats in flight -> OutValid=0 next cycle, counters unchanged.
REQ-041 SHALL cover CNTW=2 with 5 Corr beats -> CorrTot=3; then StatClr with concurrent handshake -> CorrTot=0.
REQ-042 SHALL cover reset_n low mid-stream -> all outputs 0 immediately, first new beat emerges 2 cycles after acceptance.
